// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Takes operands straight from ID/EX and stalls the front end while an
// M-extension op runs. Produces one registered result pulse per op.
// Multiply uses radix-2 shift-add on operand magnitudes. Divide uses
// radix-2 restoring division on operand magnitudes. Signs are fixed up
// on the final step.
module ex_muldiv_unit #(
  parameter logic [5:0] MULDIV_ID_BASE = 6'd37,
  parameter int         XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      instr_id_in,
  input  logic            rd_valid_in,
  input  logic [4:0]      rd_addr_in,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] rs2_value_in,
  input  logic            flush,
  output logic            stall_out,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_out
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Operation index = instr_id - MULDIV_ID_BASE
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [2:0]        op_reg;
  logic              neg_reg;
  logic [XLEN-1:0]   opa_reg;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_reg;     // mul: {partial hi, multiplier/product lo}; div: {remainder, dividend/quotient}
  logic [4:0]        rd_pend_reg;

  // Decode of the ID/EX instruction
  logic [6:0] id_off;
  logic       is_md;
  logic       start;
  logic [2:0] op_dec;

  // An out-of-range ID wraps to a large offset, so one compare covers both bounds
  assign id_off = {1'b0, instr_id_in} - {1'b0, MULDIV_ID_BASE};
  assign is_md  = (id_off < 7'd8);
  assign op_dec = id_off[2:0];
  assign start  = rd_valid_in & is_md & ~flush;

  logic            is_div;
  logic            is_rem;
  logic            rs1_signed;
  logic            rs2_signed;
  logic            s1;
  logic            s2;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic            neg_dec;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [XLEN-1:0] special_val;

  // Operand magnitudes, result sign, and special-case detection for the start cycle
  always_comb begin
    is_div     = op_dec[2];
    is_rem     = op_dec[2] & op_dec[1];
    // MUL's low word does not depend on signedness, so it runs unsigned
    rs1_signed = (op_dec == OP_MULH) | (op_dec == OP_MULHSU) |
                 (op_dec == OP_DIV)  | (op_dec == OP_REM);
    rs2_signed = (op_dec == OP_MULH) | (op_dec == OP_DIV) | (op_dec == OP_REM);
    s1         = rs1_signed & rs1_value_in[XLEN-1];
    s2         = rs2_signed & rs2_value_in[XLEN-1];
    abs1       = s1 ? (~rs1_value_in + 1'b1) : rs1_value_in;
    abs2       = s2 ? (~rs2_value_in + 1'b1) : rs2_value_in;
    div_zero   = is_div & (rs2_value_in == '0);
    div_ovf    = is_div & rs1_signed &
                 (rs1_value_in == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_value_in == '1);
    special    = div_zero | div_ovf;
    if (div_zero) begin
      special_val = is_rem ? rs1_value_in : '1;
    end else begin
      // Signed overflow: quotient is the dividend, remainder is zero
      special_val = is_rem ? '0 : rs1_value_in;
    end
    neg_dec    = is_rem ? s1 : (s1 ^ s2);
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] acc_neg;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   calc_val;
  logic              unused_bits;

  // One radix-2 step and the sign-corrected result of that step
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                (acc_reg[0] ? {1'b0, opa_reg} : {(XLEN+1){1'b0}});
    div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opa_reg};
    if (op_reg[2]) begin
      if (div_diff[XLEN+1]) begin
        acc_step = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
      end else begin
        acc_step = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_step = {mul_sum, acc_reg[XLEN-1:1]};
    end
    acc_neg = neg_reg ? (~acc_step + 1'b1) : acc_step;
    quo     = acc_step[XLEN-1:0];
    rem     = acc_step[2*XLEN-1:XLEN];
    case (op_reg)
      OP_MUL:                      calc_val = acc_step[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_val = acc_neg[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             calc_val = neg_reg ? (~quo + 1'b1) : quo;
      default:                     calc_val = neg_reg ? (~rem + 1'b1) : rem;
    endcase
  end

  // These bits are always zero or not needed for the selected result
  assign unused_bits = ^{div_diff[XLEN], acc_neg[XLEN-1:0]};

  // The start cycle and every CALC cycle hold the pipeline. A flush releases it at once.
  assign stall_out = ~rst & (((state_reg == IDLE) & start) |
                             ((state_reg == CALC) & ~flush));

  // Control FSM and iterative datapath with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      op_reg       <= '0;
      neg_reg      <= 1'b0;
      opa_reg      <= '0;
      acc_reg      <= '0;
      rd_pend_reg  <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      rd_addr_out  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          result_valid <= 1'b0;
          if (start) begin
            op_reg      <= op_dec;
            neg_reg     <= neg_dec;
            rd_pend_reg <= rd_addr_in;
            if (special) begin
              state_reg    <= DONE;
              result_valid <= 1'b1;
              result       <= special_val;
              rd_addr_out  <= rd_addr_in;
            end else begin
              state_reg <= CALC;
              busy      <= 1'b1;
              count_reg <= CNT_LAST;
              if (is_div) begin
                opa_reg <= abs2;
                acc_reg <= {{XLEN{1'b0}}, abs1};
              end else begin
                opa_reg <= abs1;
                acc_reg <= {{XLEN{1'b0}}, abs2};
              end
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            acc_reg <= acc_step;
            if (count_reg == '0) begin
              state_reg    <= DONE;
              busy         <= 1'b0;
              result_valid <= 1'b1;
              result       <= calc_val;
              rd_addr_out  <= rd_pend_reg;
            end else begin
              count_reg <= count_reg - CNT_ONE;
            end
          end
        end
        DONE: begin
          // Start is ignored here because the instruction in ID/EX is the one just finished
          state_reg    <= IDLE;
          result_valid <= 1'b0;
        end
        default: begin
          state_reg    <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage. It directly consumes the ID/EX pipeline register outputs (instr_id, operand values, rd address).
- While an M-extension operation is in flight, it drives a stall that holds ID/EX and the front end.
- It emits one registered result pulse for writeback muxing.
- Non-M instructions pass by untouched; the ALU handles them.

Parameters:
MULDIV_ID_BASE, 6'd37, instr_id of MUL. Base+1..+7 are MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU in that order.
XLEN, 32, operand/result width. Only 32 is supported.

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous active-high reset
instr_id_in  input  6  instruction ID from ID/EX
rd_valid_in  input  1  rd valid from ID/EX
rd_addr_in  input  5  destination register from ID/EX
rs1_value_in  input  32  forwarded rs1 operand
rs2_value_in  input  32  forwarded rs2 operand
flush  input  1  branch/trap flush; kills the in-flight op
stall_out  output  1  combinational; holds ID/EX and upstream stages
busy  output  1  registered; high in CALC
result_valid  output  1  registered one-cycle pulse
result  output  32  registered result, valid with result_valid
rd_addr_out  output  5  registered destination, valid with result_valid

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on rst. rst dominates flush and start.
  - Reset state: state=IDLE, busy=0, result_valid=0, result=0, rd_addr_out=0, counter=0.
  - rst mid-operation aborts the op with no result pulse.
- Start condition: start = rd_valid_in & (instr_id_in in MULDIV_ID_BASE..+7) & !flush.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start: latch the operation, rd_addr, |rs1| and |rs2| per signedness, and the result-sign flags. stall_out=1 combinationally in this cycle.
  - Next state: DONE for divide special cases, otherwise CALC with counter=31.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply (64-bit product), restoring divide for divide.
  - counter decrements each cycle; when counter==0, go to DONE.
  - stall_out=1 throughout; busy=1.
- DONE:
  - result_valid=1 for exactly one cycle. Sign correction is applied before registering.
  - stall_out=0 so ID/EX advances; start is ignored in DONE to avoid re-triggering on the held instruction.
  - Next state: IDLE.
- Latency:
  - Normal op: stall_out high for 33 cycles (start cycle plus 32 CALC); result_valid in the 34th cycle.
  - Special-case divide: stall_out high for 1 cycle; result_valid in the 2nd cycle.
- Result selection:
  - MUL: product[31:0].
  - MULH, MULHSU, MULHU: product[63:32] with signed×signed, signed×unsigned, unsigned×unsigned operands respectively.
  - Signed ops negate the 64-bit magnitude product when the operand signs differ.
- Divide special cases (no CALC):
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the rs1 value.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
- Signs: quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
- flush in CALC or DONE: go to IDLE next cycle, result_valid=0, stall_out=0 in that cycle.
- Outputs outside DONE: result and rd_addr_out hold their last values; consumers qualify with result_valid.
- A non-M instr_id, or rd_valid_in=0: no effect, stall_out=0.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD -> stall_out high 33 cycles, then one result_valid with result=0xFFFFFFEB and rd_addr_out=rd_addr_in.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000. Each: stall_out exactly 1 cycle, result_valid the next cycle.
- flush at CALC cycle 10 -> no result_valid, IDLE next cycle. Repeat with rst mid-CALC -> all outputs 0 next cycle.
- ADD instr_id, then MUL held by stall, then a new MUL in the cycle after DONE -> no stall for ADD; exactly two result pulses with no re-trigger.
